imem_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the single-cycle MIPS core. It receives a framed byte stream over a valid/ready handshake and packs the bytes into big-endian 32-bit words. It writes those words into the instruction memory's write port and holds the core in reset until a complete, checksum-verified image has been written. On a framing or checksum error it stays in an error state and never releases the core.

---
 rtl/imem_loader_pkg.sv | 25 ++
 rtl/imem_loader_if.sv | 14 +
 rtl/imem_loader_word_packer.sv | 42 ++++
 rtl/imem_loader.sv | 148 ++++++++++++++
 tb/tb_imem_loader.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
// Shared definitions for the boot-time instruction-memory loader:
//   - state_t         : loader FSM states
//   - BYTES_PER_WORD  : stream bytes packed into one instruction word
//   - LEN_BYTES       : bytes in the big-endian frame length field
//   - takes_bytes()   : true in states where the stream is consumed
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BYTES      = 2;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  function automatic logic takes_bytes(input state_t s);
    return (s == LEN_HI) || (s == LEN_LO) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if
// Byte-stream valid/ready channel feeding the loader.
//   in_data  : stream byte
//   in_valid : in_data is valid (driven by the source)
//   in_ready : loader accepts a byte this cycle (driven by the loader)
// Modports: master = byte source, slave = loader.
interface imem_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/imem_loader_word_packer.sv
// word_packer
// Packs bytes MSB-first into 32-bit words.
//   clk, reset : clock, asynchronous active-low reset
//   clear      : synchronous clear of the partial word and byte phase
//   shift_en   : a byte is being consumed this cycle
//   byte_in    : the byte being consumed
//   word_valid : this cycle's byte completes a word
//   word       : completed word (valid together with word_valid)
module word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  // Only the first three bytes need storage; the fourth is taken
  // straight from byte_in so the word is available in the same cycle.
  logic [23:0] shift_reg;
  logic [1:0]  phase_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_reg <= '0;
      phase_reg <= '0;
    end else if (clear) begin
      shift_reg <= '0;
      phase_reg <= '0;
    end else if (shift_en) begin
      shift_reg <= {shift_reg[15:0], byte_in};
      phase_reg <= phase_reg + 2'd1;
    end
  end

  assign word_valid = shift_en && (phase_reg == 2'(BYTES_PER_WORD - 1));
  assign word       = {shift_reg, byte_in};

endmodule

// File: rtl/imem_loader.sv
// imem_loader
// Boot loader: receives a framed byte stream (LEN_HI, LEN_LO, N*4 payload
// bytes, CSUM = XOR of all preceding bytes), writes big-endian words into
// the instruction memory and holds the core in reset until the image is
// complete and its checksum verified. DONE and ERR are sticky until start.
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset
//   start      : one-cycle pulse that aborts any load and restarts framing
//   stream     : byte stream (slave side of imem_loader_if)
//   imem_we    : registered write strobe, one cycle per word
//   imem_addr  : registered word index, held between writes
//   imem_data  : registered word, held between writes
//   cpu_reset  : active-high core reset, low only when DONE
//   done       : image loaded and verified
//   error      : length overflow or checksum mismatch
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int IMEM_WORDS = 256,
  parameter int ADDR_W     = $clog2(IMEM_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  imem_loader_if.slave      stream,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_data,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  // One extra bit so a full IMEM_WORDS image never wraps the counter.
  localparam int CNT_W = ADDR_W + 1;
  localparam int LEN_W = LEN_BYTES * 8;

  state_t            state_reg, state_next;
  logic [7:0]        len_hi_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [CNT_W-1:0]  word_cnt_reg;
  logic [7:0]        xor_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       data_reg;

  logic              accept;
  logic [LEN_W-1:0]  len_word;
  logic              last_word;
  logic              word_valid;
  logic [31:0]       word;

  assign stream.in_ready = takes_bytes(state_reg) && !start;
  assign accept          = stream.in_valid && stream.in_ready;

  // Full length as seen while LEN_LO is on the bus.
  assign len_word  = {len_hi_reg, stream.in_data};
  assign last_word = (LEN_W'(word_cnt_reg) + LEN_W'(1)) == len_reg;

  word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (start),
    .shift_en   (accept && (state_reg == DATA)),
    .byte_in    (stream.in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= LEN_HI;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cpu_reset  = 1'b1;
    done       = 1'b0;
    error      = 1'b0;

    if (start) begin
      state_next = LEN_HI;
    end else if (accept) begin
      case (state_reg)
        LEN_HI: state_next = LEN_LO;
        LEN_LO: begin
          if (32'(len_word) > IMEM_WORDS) state_next = ERR;
          else if (len_word == '0)        state_next = CSUM;
          else                            state_next = DATA;
        end
        DATA:   if (word_valid && last_word) state_next = CSUM;
        CSUM:   state_next = (stream.in_data == xor_reg) ? DONE : ERR;
        default: ;
      endcase
    end

    case (state_reg)
      DONE: begin
        cpu_reset = 1'b0;
        done      = 1'b1;
      end
      ERR:  error = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_hi_reg   <= '0;
      len_reg      <= '0;
      word_cnt_reg <= '0;
      xor_reg      <= '0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      data_reg     <= '0;
    end else begin
      we_reg <= 1'b0;
      if (start) begin
        word_cnt_reg <= '0;
        xor_reg      <= '0;
      end else if (accept) begin
        // The CSUM byte itself is compared, never folded in.
        if (state_reg != CSUM) xor_reg <= xor_reg ^ stream.in_data;
        case (state_reg)
          LEN_HI: len_hi_reg <= stream.in_data;
          LEN_LO: len_reg    <= len_word;
          DATA: begin
            if (word_valid) begin
              we_reg       <= 1'b1;
              addr_reg     <= word_cnt_reg[ADDR_W-1:0];
              data_reg     <= word;
              word_cnt_reg <= word_cnt_reg + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign imem_we   = we_reg;
  assign imem_addr = addr_reg;
  assign imem_data = data_reg;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Self-checking bench for imem_loader: a constant vector table, random
// frames checked against a frame-level reference model, and hand-written
// sequences for the 256-word image, restart and asynchronous reset.
module tb_imem_loader;

  localparam int IMEM_WORDS = 256;
  localparam int ADDR_W     = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic              cpu_reset;
  logic              done;
  logic              error;

  imem_loader_if bus ();

  imem_loader #(.IMEM_WORDS(IMEM_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stream    (bus),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int               nbytes;
    logic [0:15][7:0] b;
    logic             exp_done;
    logic             exp_err;
    int               exp_nwr;
    logic [31:0]      exp_w0;
    logic [31:0]      exp_w1;
  } vec_t;

  wr_t        wr_q[$];
  wr_t        exp_q[$];
  logic [7:0] fr_q[$];
  logic       exp_done;
  logic       exp_err;
  int         checks      = 0;
  int         failures    = 0;
  int         we_released = 0;
  vec_t       vt[4];

  // Write monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset && imem_we) begin
      wr_q.push_back({imem_addr, imem_data});
      if (!cpu_reset) we_released++;
    end
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Reference model: parse the frame by its rules and list the expected
  // writes and final status.
  task automatic build_expect();
    int         n;
    logic [7:0] x;
    exp_q.delete();
    n = int'({fr_q[0], fr_q[1]});
    if (n > IMEM_WORDS) begin
      exp_err  = 1'b1;
      exp_done = 1'b0;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < 2 + 4 * n; i++) x = x ^ fr_q[i];
    for (int w = 0; w < n; w++)
      exp_q.push_back({8'(w), fr_q[2+4*w], fr_q[3+4*w], fr_q[4+4*w], fr_q[5+4*w]});
    exp_done = (fr_q[2+4*n] == x);
    exp_err  = !exp_done;
  endtask

  // Present one byte after `gap` idle cycles; returns one step after the
  // accepting edge. Called and returning at posedge+1.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int tries;
    repeat (gap) begin
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    tries        = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      tries++;
      if (tries > 50) begin
        chk("stall_timeout", 32'(tries), 32'd0);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic do_start();
    bus.in_valid = 1'b0;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start cpu_reset", 32'(cpu_reset), 32'd1);
    chk("start done", 32'(done), 32'd0);
    chk("start error", 32'(error), 32'd0);
  endtask

  task automatic run_frame(input bit use_start, input int gapmax, input string tag);
    int mism;
    int lim;
    if (use_start) do_start();
    wr_q.delete();
    build_expect();
    foreach (fr_q[i]) send_byte(fr_q[i], int'($urandom_range(0, gapmax)));
    chk({tag, " done_next_cycle"}, 32'(done), 32'(exp_done));
    chk({tag, " error_next_cycle"}, 32'(error), 32'(exp_err));
    repeat (6) begin
      @(posedge clk); #1;
    end
    chk({tag, " write_count"}, 32'(wr_q.size()), 32'(exp_q.size()));
    mism = 0;
    lim  = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
    for (int i = 0; i < lim; i++) begin
      if (wr_q[i] !== exp_q[i]) begin
        if (mism == 0)
          $display("  detail %s idx=%0d got=%h want=%h", tag, i, wr_q[i], exp_q[i]);
        mism++;
      end
    end
    chk({tag, " write_contents_bad"}, 32'(mism), 32'd0);
    chk({tag, " cpu_reset"}, 32'(cpu_reset), 32'(!exp_done));
    chk({tag, " in_ready_after"}, 32'(bus.in_ready), 32'd0);
  endtask

  initial begin
    logic [15:0] n16;
    logic [7:0]  x;
    logic [7:0]  b;

    reset        = 1'b0;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Constant vector table.
    vt[0] = '{11, {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h08, 8'h40, 8'h20, 8'h46, 40'h0},
              1'b1, 1'b0, 2, 32'h2008_0005, 32'h0108_4020};
    vt[1] = '{11, {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h08, 8'h40, 8'h20, 8'h47, 40'h0},
              1'b0, 1'b1, 2, 32'h2008_0005, 32'h0108_4020};
    vt[2] = '{3, {8'h00, 8'h00, 8'h00, 104'h0}, 1'b1, 1'b0, 0, 32'h0, 32'h0};
    vt[3] = '{2, {8'h01, 8'h01, 112'h0}, 1'b0, 1'b1, 0, 32'h0, 32'h0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst done", 32'(done), 32'd0);
    chk("rst error", 32'(error), 32'd0);
    chk("rst imem_we", 32'(imem_we), 32'd0);
    chk("rst imem_addr", 32'(imem_addr), 32'd0);
    chk("rst imem_data", imem_data, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Table-driven vectors, back-to-back bytes.
    for (int v = 0; v < 4; v++) begin
      do_start();
      wr_q.delete();
      for (int i = 0; i < vt[v].nbytes; i++) send_byte(vt[v].b[i], 0);
      chk($sformatf("vec%0d done_next_cycle", v), 32'(done), 32'(vt[v].exp_done));
      chk($sformatf("vec%0d error_next_cycle", v), 32'(error), 32'(vt[v].exp_err));
      repeat (6) begin
        @(posedge clk); #1;
      end
      chk($sformatf("vec%0d write_count", v), 32'(wr_q.size()), 32'(vt[v].exp_nwr));
      if (vt[v].exp_nwr >= 1) begin
        chk($sformatf("vec%0d w0_addr", v), (wr_q.size() >= 1) ? 32'(wr_q[0].addr) : 32'hxxxx_xxxx, 32'd0);
        chk($sformatf("vec%0d w0_data", v), (wr_q.size() >= 1) ? wr_q[0].data : 32'hxxxx_xxxx, vt[v].exp_w0);
      end
      if (vt[v].exp_nwr >= 2) begin
        chk($sformatf("vec%0d w1_addr", v), (wr_q.size() >= 2) ? 32'(wr_q[1].addr) : 32'hxxxx_xxxx, 32'd1);
        chk($sformatf("vec%0d w1_data", v), (wr_q.size() >= 2) ? wr_q[1].data : 32'hxxxx_xxxx, vt[v].exp_w1);
      end
      chk($sformatf("vec%0d cpu_reset", v), 32'(cpu_reset), 32'(!vt[v].exp_done));
      chk($sformatf("vec%0d in_ready", v), 32'(bus.in_ready), 32'd0);
      $display("vec%0d done=%0b error=%0b writes=%0d", v, done, error, wr_q.size());
    end

    // Two-word frame with random gaps.
    fr_q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h08, 8'h40, 8'h20, 8'h46};
    run_frame(1'b1, 3, "gaps");
    $display("gaps done=%0b writes=%0d", done, wr_q.size());

    // Maximum-length image.
    fr_q.delete();
    fr_q.push_back(8'h01);
    fr_q.push_back(8'h00);
    x = 8'h01;
    for (int i = 0; i < 4 * IMEM_WORDS; i++) begin
      b = 8'($urandom);
      fr_q.push_back(b);
      x = x ^ b;
    end
    fr_q.push_back(x);
    run_frame(1'b1, 0, "full256");
    chk("full256 last_addr", (wr_q.size() == 256) ? 32'(wr_q[255].addr) : 32'hxxxx_xxxx, 32'd255);
    $display("full256 done=%0b writes=%0d", done, wr_q.size());

    // Restart after 5 bytes; a byte offered during start must be ignored.
    do_start();
    fr_q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h08, 8'h40, 8'h20, 8'h46};
    for (int i = 0; i < 5; i++) send_byte(fr_q[i], 0);
    start        = 1'b1;
    bus.in_data  = 8'hFF;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("restart in_ready_during_start", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    chk("restart cpu_reset", 32'(cpu_reset), 32'd1);
    run_frame(1'b0, 0, "restart");
    $display("restart done=%0b writes=%0d", done, wr_q.size());

    // Asynchronous reset in the middle of DATA.
    do_start();
    for (int i = 0; i < 7; i++) send_byte(fr_q[i], 0);
    #2 reset = 1'b0;
    #1;
    chk("areset in_ready", 32'(bus.in_ready), 32'd1);
    chk("areset cpu_reset", 32'(cpu_reset), 32'd1);
    chk("areset done", 32'(done), 32'd0);
    chk("areset error", 32'(error), 32'd0);
    chk("areset imem_we", 32'(imem_we), 32'd0);
    chk("areset imem_addr", 32'(imem_addr), 32'd0);
    chk("areset imem_data", imem_data, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    run_frame(1'b0, 1, "post_reset");
    $display("post_reset done=%0b writes=%0d", done, wr_q.size());

    // Random frames against the reference model.
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 7) == 7) n16 = 16'($urandom_range(257, 400));
      else                           n16 = 16'($urandom_range(0, 6));
      fr_q.delete();
      fr_q.push_back(n16[15:8]);
      fr_q.push_back(n16[7:0]);
      if (int'(n16) <= IMEM_WORDS) begin
        x = n16[15:8] ^ n16[7:0];
        for (int i = 0; i < 4 * int'(n16); i++) begin
          b = 8'($urandom);
          fr_q.push_back(b);
          x = x ^ b;
        end
        if ($urandom_range(0, 3) == 0) x = x ^ 8'($urandom_range(1, 255));
        fr_q.push_back(x);
      end
      run_frame(1'b1, 2, $sformatf("rand%0d", t));
      $display("rand%0d n=%0d done=%0b error=%0b writes=%0d", t, n16, done, error, wr_q.size());
    end

    chk("we_with_core_released", 32'(we_released), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
